// File: rtl/piradip_sample_sequencer_pkg.sv
// Shared types and helpers for the sample-buffer capture sequencer.
package piradip_sample_sequencer;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN
  } seq_state_t;

  // Index width that stays legal for a single-entry bank.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piradip_rr_pick.sv
// Rotating-priority picker: first set bit of mask at or after ptr, wrapping at N-1.
module piradip_rr_pick
  import piradip_sample_sequencer::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              mask,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      valid
);

  localparam int IW = idx_width(N);

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[(int'(ptr) + i) % N]) begin
        idx   = IW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piradip_sample_buffer_sequencer.sv
// Round-robin one-shot capture scheduler: fires one trigger per period slot across enabled buffers.
module piradip_sample_buffer_sequencer
  import piradip_sample_sequencer::*;
#(
  parameter int NUM_BUF       = 4,
  parameter int PERIOD_WIDTH  = 32,
  parameter int COUNT_WIDTH   = 32,
  parameter int DRAIN_HOLDOFF = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [PERIOD_WIDTH-1:0]       period,
  input  logic [COUNT_WIDTH-1:0]        num_captures,
  input  logic [NUM_BUF-1:0]            buf_enable,
  input  logic [NUM_BUF-1:0]            buf_stopped,
  output logic [NUM_BUF-1:0]            trigger,
  output logic [idx_width(NUM_BUF)-1:0] buf_sel,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        capture_count,
  output logic [COUNT_WIDTH-1:0]        overrun_count
);

  localparam int IW = idx_width(NUM_BUF);
  localparam int HW = $clog2(DRAIN_HOLDOFF + 2);

  seq_state_t              state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_q, slot_cnt_q, reload;
  logic [COUNT_WIDTH-1:0]  num_q, attempts_q;
  logic [NUM_BUF-1:0]      en_q;
  logic [IW-1:0]           ptr_q, sel, ptr_next;
  logic [HW-1:0]           hold_cnt_q;
  logic                    sel_valid, slot, last_slot, hold_done, all_idle, accept;

  piradip_rr_pick #(.N(NUM_BUF)) u_pick (
    .mask  (en_q),
    .ptr   (ptr_q),
    .idx   (sel),
    .valid (sel_valid)
  );

  assign accept    = start && !abort;
  assign reload    = (period_q == '0) ? '0 : period_q - PERIOD_WIDTH'(1);
  assign slot      = (state_q == SEQ_RUN) && (slot_cnt_q == '0) && sel_valid;
  assign last_slot = slot && (num_q != '0) && (attempts_q + COUNT_WIDTH'(1) == num_q);
  assign hold_done = (hold_cnt_q == HW'(DRAIN_HOLDOFF));
  assign all_idle  = &(buf_stopped | ~en_q);
  assign ptr_next  = (sel == IW'(NUM_BUF - 1)) ? '0 : sel + IW'(1);
  assign busy      = (state_q != SEQ_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= SEQ_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE:  if (accept && buf_enable != '0) state_d = SEQ_RUN;
      SEQ_RUN:   if (last_slot)                  state_d = SEQ_DRAIN;
      SEQ_DRAIN: if (hold_done && all_idle)      state_d = SEQ_IDLE;
      default:                                   state_d = SEQ_IDLE;
    endcase
    if (abort) state_d = SEQ_IDLE;
  end

  // Abort freezes everything except clearing the one-cycle pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      period_q      <= '0;
      num_q         <= '0;
      en_q          <= '0;
      slot_cnt_q    <= '0;
      attempts_q    <= '0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      trigger       <= '0;
      buf_sel       <= '0;
      done          <= 1'b0;
      capture_count <= '0;
      overrun_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      trigger <= '0;
      done    <= 1'b0;
      if (!abort) begin
        unique case (state_q)
          SEQ_IDLE: begin
            if (start) begin
              period_q      <= period;
              num_q         <= num_captures;
              en_q          <= buf_enable;
              slot_cnt_q    <= '0;
              attempts_q    <= '0;
              ptr_q         <= '0;
              hold_cnt_q    <= '0;
              capture_count <= '0;
              overrun_count <= '0;
              done          <= (buf_enable == '0);
            end
          end
          SEQ_RUN: begin
            hold_cnt_q <= '0;
            if (slot) begin
              slot_cnt_q <= reload;
              attempts_q <= attempts_q + COUNT_WIDTH'(1);
              ptr_q      <= ptr_next;
              buf_sel    <= sel;
              if (buf_stopped[sel]) begin
                trigger       <= NUM_BUF'(1) << sel;
                capture_count <= capture_count + COUNT_WIDTH'(1);
              end else begin
                overrun_count <= overrun_count + COUNT_WIDTH'(1);
              end
            end else begin
              slot_cnt_q <= slot_cnt_q - PERIOD_WIDTH'(1);
            end
          end
          SEQ_DRAIN: begin
            if (!hold_done) hold_cnt_q <= hold_cnt_q + HW'(1);
            if (hold_done && all_idle) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piradip_sample_buffer_sequencer.sv
// Self-checking bench: directed and random schedules against a slot-arithmetic reference model.
module tb_piradip_sample_buffer_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, abort;
  logic [31:0] period, num_captures;
  logic [3:0]  buf_enable, buf_stopped, trigger;
  logic [1:0]  buf_sel;
  logic        busy, done;
  logic [31:0] capture_count, overrun_count;

  int n_cmp = 0;
  int n_bad = 0;

  piradip_sample_buffer_sequencer #(
    .NUM_BUF(4), .PERIOD_WIDTH(32), .COUNT_WIDTH(32), .DRAIN_HOLDOFF(8)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .period        (period),
    .num_captures  (num_captures),
    .buf_enable    (buf_enable),
    .buf_stopped   (buf_stopped),
    .trigger       (trigger),
    .buf_sel       (buf_sel),
    .busy          (busy),
    .done          (done),
    .capture_count (capture_count),
    .overrun_count (overrun_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it; all sampling and driving happens here.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Model: slot n lands n*pe edges after the first, targets the n-th enabled buffer in
  // ascending wrap order, and fires only if that buffer reports stopped.
  task automatic run_case(input string name, input logic [3:0] en, input logic [31:0] per,
                          input logic [31:0] num, input logic [3:0] stp,
                          input int abort_tick, input bit hold_low);
    int pe, m_end, n, tgt, exp_cap, exp_ovr, waited;
    int lst[$];
    logic [3:0] exp_trig;
    bit seen;
    pe = (per == 0) ? 1 : int'(per);
    lst = {};
    for (int i = 0; i < 4; i++) if (en[i]) lst.push_back(i);
    buf_enable = en; period = per; num_captures = num; buf_stopped = stp; start = 1'b1;
    tick();
    start = 1'b0;
    period = $urandom; num_captures = $urandom; buf_enable = 4'($urandom);
    check({name, ":busy_start"}, 32'(busy), 32'd1);
    exp_cap = 0; exp_ovr = 0;
    m_end = (abort_tick > 0) ? abort_tick : (int'(num) - 1) * pe + 1;
    for (int m = 1; m <= m_end; m++) begin
      tick();
      exp_trig = '0;
      if ((m - 1) % pe == 0) begin
        n = (m - 1) / pe;
        tgt = lst[n % lst.size()];
        if (stp[tgt]) begin
          exp_trig[tgt] = 1'b1;
          exp_cap++;
        end else begin
          exp_ovr++;
        end
        check({name, ":buf_sel"}, 32'(buf_sel), 32'(tgt));
      end
      check({name, ":trigger"}, 32'(trigger), 32'(exp_trig));
      check({name, ":busy_run"}, 32'(busy), 32'd1);
    end
    if (abort_tick > 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check({name, ":busy_abort"}, 32'(busy), 32'd0);
      for (int k = 0; k < 8; k++) begin
        check({name, ":trig_after_abort"}, 32'(trigger), 32'd0);
        check({name, ":done_after_abort"}, 32'(done), 32'd0);
        tick();
      end
    end else begin
      if (hold_low) begin
        buf_stopped = 4'b0000;
        for (int k = 0; k < 20; k++) begin
          tick();
          check({name, ":no_done_while_busy_buf"}, 32'(done), 32'd0);
          check({name, ":trig_drain"}, 32'(trigger), 32'd0);
        end
      end
      buf_stopped = 4'b1111;
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 14) begin
        tick();
        waited++;
        if (done) seen = 1'b1;
        else check({name, ":busy_drain"}, 32'(busy), 32'd1);
      end
      check({name, ":done_seen"}, 32'(seen), 32'd1);
      if (hold_low) check({name, ":done_prompt"}, 32'(waited <= 3), 32'd1);
      else          check({name, ":drain_holdoff"}, 32'(waited >= 8), 32'd1);
      check({name, ":busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({name, ":done_one_cycle"}, 32'(done), 32'd0);
    end
    check({name, ":capture_count"}, capture_count, 32'(exp_cap));
    check({name, ":overrun_count"}, overrun_count, 32'(exp_ovr));
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    period = '0; num_captures = '0; buf_enable = '0; buf_stopped = '0;
    #12;
    check("rst:trigger", 32'(trigger), 32'd0);
    check("rst:buf_sel", 32'(buf_sel), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:capture", capture_count, 32'd0);
    check("rst:overrun", overrun_count, 32'd0);
    aresetn = 1'b1;
    tick();

    run_case("t1", 4'b1111, 32'd10, 32'd8, 4'b1111, 0, 1'b0);
    run_case("t2", 4'b1010, 32'd5,  32'd4, 4'b1111, 0, 1'b0);
    run_case("t3", 4'b0011, 32'd4,  32'd4, 4'b1101, 0, 1'b0);
    run_case("t4", 4'b1111, 32'd3,  32'd0, 4'b1111, 19, 1'b0);

    // Start with nothing enabled completes immediately without going busy.
    buf_enable = 4'b0000; period = 32'd4; num_captures = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5:done_empty", 32'(done), 32'd1);
    check("t5:busy_empty", 32'(busy), 32'd0);
    check("t5:capture_cleared", capture_count, 32'd0);
    tick();
    check("t5:done_pulse", 32'(done), 32'd0);

    buf_enable = 4'b1111; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t5:abort_wins_busy", 32'(busy), 32'd0);
      check("t5:abort_wins_trig", 32'(trigger), 32'd0);
      tick();
    end

    run_case("t6", 4'b0001, 32'd0, 32'd3, 4'b1111, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      logic [3:0] en_r;
      en_r = 4'($urandom_range(1, 15));
      run_case("rnd", en_r, 32'($urandom_range(0, 5)), 32'($urandom_range(1, 9)),
               4'($urandom), 0, 1'b0);
    end

    // Asynchronous reset while a trigger is high must clear outputs without waiting for an edge.
    buf_enable = 4'b1111; period = 32'd2; num_captures = 32'd0; buf_stopped = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("t6r:trig_before_rst", 32'(trigger), 32'b0100);
    #2 aresetn = 1'b0;
    #1;
    check("t6r:trigger", 32'(trigger), 32'd0);
    check("t6r:busy", 32'(busy), 32'd0);
    check("t6r:buf_sel", 32'(buf_sel), 32'd0);
    check("t6r:capture", capture_count, 32'd0);
    check("t6r:overrun", overrun_count, 32'd0);
    #1 aresetn = 1'b1;
    tick();
    check("t6r:idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
